sic_program_loader: RTL and testbench

- Boot-time stage directly upstream of the SIC CPU/memory pair.
- Accepts a byte stream over valid/ready and assembles it into 24-bit words, written to memory via a one-cycle write port.
- Holds the CPU in reset until the image is fully written, then releases the CPU and presents the load address as its start PC.
- Muxed onto the memory port by the top level while cpu_hold is high.

---
 rtl/sic_loader_pkg.sv | 21 ++
 rtl/sic_byte_packer.sv | 44 ++++
 rtl/sic_program_loader.sv | 161 ++++++++++++++++
 tb/tb_sic_program_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sic_loader_pkg.sv
// Shared types and constants for the SIC boot-time program loader.
package sic_loader_pkg;

    // Loader sequencing states, in stream order.
    typedef enum logic [2:0] {
        ADDR_HI = 3'd0,
        ADDR_LO = 3'd1,
        CNT_HI  = 3'd2,
        CNT_LO  = 3'd3,
        DATA    = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6
    } loader_state_t;

    // Header is base address (2 bytes) followed by word count (2 bytes).
    localparam int HDR_BYTES = 4;

    // Word count field width carried in the header.
    localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/sic_byte_packer.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags the
// byte that completes a word. The completed word is presented combinationally
// alongside word_valid so the caller can capture it on the same edge.
module sic_byte_packer #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_data,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word_data
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    // Only the lower bytes need storage; the incoming byte completes the word.
    logic [DATA_WIDTH-9:0] shift_q;
    logic [CNT_W-1:0]      byte_cnt_q;

    assign word_data  = {shift_q, byte_data};
    assign word_valid = shift_en && (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));

    // Shift accepted bytes in and count position within the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (clear) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (shift_en) begin
            shift_q <= word_data[DATA_WIDTH-9:0];
            if (word_valid) begin
                byte_cnt_q <= '0;
            end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sic_program_loader.sv
// SIC boot loader: parses a big-endian header (base address, word count),
// assembles data bytes into words and writes them through a one-cycle write
// port, holding the CPU in reset until the image is complete.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ADDR_HI | waiting for base address high byte (bit 15 dropped later)
// ADDR_LO | waiting for base address low byte; base latched here
// CNT_HI  | waiting for word count high byte
// CNT_LO  | waiting for word count low byte; zero count skips to DONE
// DATA    | collecting bytes of the current word
// WRITE   | single-cycle memory write strobe, input stalled
// DONE    | image loaded, CPU released, waiting for restart
module sic_program_loader
    import sic_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     restart,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_write_enable,
    output logic                     cpu_hold,
    output logic [ADDRESS_WIDTH-1:0] start_address,
    output logic                     load_done,
    output logic                     wrap_error
);

    loader_state_t            state;
    logic [7:0]               addr_hi_q;
    logic [7:0]               cnt_hi_q;
    logic [ADDRESS_WIDTH-1:0] ptr_q;
    logic [COUNT_WIDTH-1:0]   remaining_q;

    logic                     transfer;
    logic                     packer_shift;
    logic                     packer_clear;
    logic                     word_valid;
    logic [DATA_WIDTH-1:0]    word_data;
    logic [ADDRESS_WIDTH-1:0] base_address;
    logic [COUNT_WIDTH-1:0]   word_count;
    logic                     restart_accepted;

    // Ready depends on state only, so in_valid never reaches in_ready.
    assign in_ready = (state != WRITE) && (state != DONE);
    assign transfer = in_valid && in_ready;

    assign packer_shift     = transfer && (state == DATA);
    assign restart_accepted = restart && (state == DONE);
    assign packer_clear     = restart_accepted;

    // Upper address bits beyond the memory width are discarded.
    assign base_address = ADDRESS_WIDTH'({addr_hi_q, in_data});
    assign word_count   = {cnt_hi_q, in_data};

    sic_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .shift_en   (packer_shift),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // Loader sequencer with registered memory, hold and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ADDR_HI;
            addr_hi_q        <= '0;
            cnt_hi_q         <= '0;
            ptr_q            <= '0;
            remaining_q      <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            cpu_hold         <= 1'b1;
            start_address    <= '0;
            load_done        <= 1'b0;
            wrap_error       <= 1'b0;
        end else begin
            case (state)
                ADDR_HI: begin
                    if (transfer) begin
                        addr_hi_q <= in_data;
                        state     <= ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (transfer) begin
                        ptr_q         <= base_address;
                        start_address <= base_address;
                        state         <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (transfer) begin
                        cnt_hi_q <= in_data;
                        state    <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (transfer) begin
                        remaining_q <= word_count;
                        if (word_count == '0) begin
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        mem_write_enable <= 1'b1;
                        mem_address      <= ptr_q;
                        mem_write_data   <= word_data;
                        state            <= WRITE;
                    end
                end
                WRITE: begin
                    mem_write_enable <= 1'b0;
                    ptr_q            <= ptr_q + 1'b1;
                    remaining_q      <= remaining_q - 1'b1;
                    // Wrapping only matters if another word will land at 0.
                    if ((ptr_q == '1) && (remaining_q != COUNT_WIDTH'(1))) begin
                        wrap_error <= 1'b1;
                    end
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state     <= DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DONE: begin
                    if (restart_accepted) begin
                        state      <= ADDR_HI;
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        wrap_error <= 1'b0;
                    end
                end
                default: begin
                    state <= ADDR_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sic_program_loader.sv
// Directed bench for sic_program_loader: expected memory writes are queued as
// words are streamed and checked against the write port as strobes appear.
module tb_sic_program_loader;

    localparam int AW = 15;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          restart = 1'b0;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_enable;
    logic          cpu_hold;
    logic [AW-1:0] start_address;
    logic          load_done;
    logic          wrap_error;

    always #5 clk = ~clk;

    sic_program_loader #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .restart          (restart),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .cpu_hold         (cpu_hold),
        .start_address    (start_address),
        .load_done        (load_done),
        .wrap_error       (wrap_error)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;
    logic prev_we  = 1'b0;
    int   wcount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Write-port monitor: pop scoreboard on each strobe.
    always @(negedge clk) begin
        if (mem_write_enable) begin
            n_writes++;
            check("we_single_cycle", 32'(prev_we), 0);
            check("ready_low_in_write", 32'(in_ready), 0);
            check("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_address), 32'(mon_e.a));
                check("wr_data", 32'(mem_write_data), 32'(mon_e.d));
            end
        end
        prev_we = mem_write_enable;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit done;
        done = 1'b0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        check("byte_accept", 32'(done), 1);
    endtask

    task automatic send_header(input logic [15:0] addr, input logic [15:0] cnt, input bit gaps);
        send_byte(addr[15:8], gaps);
        send_byte(addr[7:0], gaps);
        send_byte(cnt[15:8], gaps);
        send_byte(cnt[7:0], gaps);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit gaps);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
        send_byte(d[23:16], gaps);
        send_byte(d[15:8], gaps);
        send_byte(d[7:0], gaps);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (load_done) seen = 1'b1;
        end
        check("load_done_reached", 32'(seen), 1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_hold", 32'(cpu_hold), 1);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_wrap", 32'(wrap_error), 0);
        check("rst_we", 32'(mem_write_enable), 0);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_wdata", 32'(mem_write_data), 0);
        check("rst_start", 32'(start_address), 0);
        rst = 1'b0;

        // Basic two-word load, back-to-back bytes.
        send_header(16'h0010, 16'd2, 1'b0);
        send_word(15'h0010, 24'h123456, 1'b0);
        send_word(15'h0011, 24'hABCDEF, 1'b0);
        wait_done();
        check("t1_cpu_hold", 32'(cpu_hold), 0);
        check("t1_start", 32'(start_address), 32'h0010);
        check("t1_in_ready", 32'(in_ready), 0);
        check("t1_wrap", 32'(wrap_error), 0);
        check("t1_writes", 32'(n_writes), 2);
        check("t1_queue_empty", 32'(exp_q.size()), 0);

        // Restart from DONE, then a zero-count image.
        pulse_restart();
        check("rs_cpu_hold", 32'(cpu_hold), 1);
        check("rs_load_done", 32'(load_done), 0);
        check("rs_in_ready", 32'(in_ready), 1);
        wcount = n_writes;
        send_header(16'h0020, 16'd0, 1'b0);
        check("t2_done_direct", 32'(load_done), 1);
        check("t2_cpu_hold", 32'(cpu_hold), 0);
        check("t2_start", 32'(start_address), 32'h0020);
        repeat (3) @(posedge clk);
        #1;
        check("t2_no_writes", 32'(n_writes), 32'(wcount));

        // Address wrap past all-ones with a word remaining; bit 15 dropped.
        pulse_restart();
        send_header(16'h7FFF, 16'd2, 1'b0);
        send_word(15'h7FFF, 24'h010203, 1'b0);
        send_word(15'h0000, 24'h0A0B0C, 1'b0);
        wait_done();
        check("t3_wrap", 32'(wrap_error), 1);
        check("t3_start", 32'(start_address), 32'h7FFF);
        repeat (5) @(posedge clk);
        #1;
        check("t3_wrap_sticky", 32'(wrap_error), 1);
        pulse_restart();
        check("t3_wrap_cleared", 32'(wrap_error), 0);
        check("t3_hold_again", 32'(cpu_hold), 1);

        // Last word at all-ones: no further word, so no wrap flag.
        send_header(16'hFFFF, 16'd1, 1'b0);
        send_word(15'h7FFF, 24'h55AA33, 1'b0);
        wait_done();
        check("t3b_no_wrap", 32'(wrap_error), 0);

        // Same image as the first load with random valid gaps.
        pulse_restart();
        wcount = n_writes;
        send_header(16'h0010, 16'd2, 1'b1);
        send_word(15'h0010, 24'h123456, 1'b1);
        send_word(15'h0011, 24'hABCDEF, 1'b1);
        wait_done();
        check("t4_writes", 32'(n_writes - wcount), 2);
        check("t4_start", 32'(start_address), 32'h0010);

        // Restart mid-DATA is ignored.
        pulse_restart();
        send_header(16'h0040, 16'd2, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        pulse_restart();
        check("t5_hold_kept", 32'(cpu_hold), 1);
        check("t5_not_done", 32'(load_done), 0);
        check("t5_ready", 32'(in_ready), 1);
        begin
            wr_t w;
            w.a = 15'h0040;
            w.d = 24'h112233;
            exp_q.push_back(w);
        end
        send_byte(8'h33, 1'b0);
        send_word(15'h0041, 24'h445566, 1'b0);
        wait_done();
        check("t5_start", 32'(start_address), 32'h0040);

        // Reset in the middle of the second word.
        pulse_restart();
        send_header(16'h0100, 16'd2, 1'b0);
        send_word(15'h0100, 24'h123456, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_cpu_hold", 32'(cpu_hold), 1);
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_we", 32'(mem_write_enable), 0);
        check("t6_addr", 32'(mem_address), 0);
        check("t6_wdata", 32'(mem_write_data), 0);
        check("t6_start", 32'(start_address), 0);
        check("t6_load_done", 32'(load_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_header(16'h0010, 16'd2, 1'b0);
        send_word(15'h0010, 24'h0F0E0D, 1'b0);
        send_word(15'h0011, 24'h0C0B0A, 1'b0);
        wait_done();
        check("t6_reload_start", 32'(start_address), 32'h0010);
        check("t6_reload_hold", 32'(cpu_hold), 0);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
